end_screen_draw: RTL and testbench

- Downstream consumer of the full-screen image ROMs (lose/win/start screens, 12-bit RGB444 words, 20-bit address, one-cycle registered read).
- Sits in the VGA timing chain. Converts the incoming hcount/vcount into a ROM address and takes the returned pixel.
- Aligns the pixel with delayed timing signals and applies a per-frame fade-in before passing the stream to the next draw stage.
- When disabled, it acts as a latency-matched pass-through of the upstream RGB.

---
 rtl/end_screen_draw.sv | 157 +++++++++++++++
 tb/tb_end_screen_draw.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/end_screen_draw.sv
// Full-screen image overlay stage: fetches a ROM pixel per timing position, aligns it
// with 2-clk delayed timing and applies a per-frame fade-in, or bypasses upstream RGB.
module end_screen_draw #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 12,
    parameter int FADE_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [10:0]           vcount_in,
    input  logic                  vsync_in,
    input  logic                  vblnk_in,
    input  logic [10:0]           hcount_in,
    input  logic                  hsync_in,
    input  logic                  hblnk_in,
    input  logic [11:0]           rgb_in,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [10:0]           vcount_out,
    output logic                  vsync_out,
    output logic                  vblnk_out,
    output logic [10:0]           hcount_out,
    output logic                  hsync_out,
    output logic                  hblnk_out,
    output logic [11:0]           rgb_out
);
    localparam int CNT_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam int CHANNELS = DATA_WIDTH / 4;

    typedef enum logic [1:0] {IDLE, FADING, FULL} state_t;

    state_t           state_reg, state_next;
    logic [4:0]       level_reg, level_next;
    logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic             frame_start;

    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            level_reg     <= 5'd0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            level_reg     <= level_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // Disable overrides everything, including a level step due on the same cycle.
    always_comb begin
        state_next     = state_reg;
        level_next     = level_reg;
        frame_cnt_next = frame_cnt_reg;
        if (!enable) begin
            state_next     = IDLE;
            level_next     = 5'd0;
            frame_cnt_next = '0;
        end else if (frame_start) begin
            case (state_reg)
                IDLE: begin
                    state_next     = FADING;
                    level_next     = 5'd0;
                    frame_cnt_next = '0;
                end
                FADING: begin
                    if (frame_cnt_reg == CNT_W'(FADE_FRAMES - 1)) begin
                        frame_cnt_next = '0;
                        level_next     = level_reg + 5'd1;
                        if (level_reg == 5'd15)
                            state_next = FULL;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + CNT_W'(1);
                    end
                end
                FULL:    state_next = FULL;
                default: state_next = IDLE;
            endcase
        end
    end

    logic [10:0] vcount_s1, hcount_s1;
    logic        vsync_s1, vblnk_s1, hsync_s1, hblnk_s1, enable_s1;
    logic [11:0] rgb_s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr  <= '0;
            vcount_s1 <= 11'd0;
            vsync_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
            hcount_s1 <= 11'd0;
            hsync_s1  <= 1'b0;
            hblnk_s1  <= 1'b0;
            rgb_s1    <= 12'd0;
            enable_s1 <= 1'b0;
        end else begin
            rom_addr  <= ADDR_WIDTH'({vcount_in[9:0], hcount_in[9:0]});
            vcount_s1 <= vcount_in;
            vsync_s1  <= vsync_in;
            vblnk_s1  <= vblnk_in;
            hcount_s1 <= hcount_in;
            hsync_s1  <= hsync_in;
            hblnk_s1  <= hblnk_in;
            rgb_s1    <= rgb_in;
            enable_s1 <= enable;
        end
    end

    // The ROM's own output register is the second pipeline stage for the pixel data,
    // so only the controls and the level travel through stage 2 here.
    logic        blank_s2, enable_s2;
    logic [11:0] rgb_s2;
    logic [4:0]  level_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vcount_out <= 11'd0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            blank_s2   <= 1'b0;
            enable_s2  <= 1'b0;
            rgb_s2     <= 12'd0;
            level_s2   <= 5'd0;
        end else begin
            vcount_out <= vcount_s1;
            vsync_out  <= vsync_s1;
            vblnk_out  <= vblnk_s1;
            hcount_out <= hcount_s1;
            hsync_out  <= hsync_s1;
            hblnk_out  <= hblnk_s1;
            blank_s2   <= hblnk_s1 | vblnk_s1;
            enable_s2  <= enable_s1;
            rgb_s2     <= rgb_s1;
            level_s2   <= level_reg;
        end
    end

    logic [DATA_WIDTH-1:0] scaled;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
        logic [8:0] prod;
        assign prod = {5'd0, rom_data[gi*4 +: 4]} * {4'd0, level_s2};
        assign scaled[gi*4 +: 4] = prod[7:4];
    end

    always_comb begin
        rgb_out = 12'h000;
        if (!blank_s2)
            rgb_out = enable_s2 ? scaled : rgb_s2;
    end
endmodule

// File: tb/tb_end_screen_draw.sv
// Directed bench for end_screen_draw on a small synthetic raster (16x8, active 12x6),
// with a registered-read ROM model and a queue-based scoreboard of expected outputs.
module tb_end_screen_draw;
    localparam int FF = 4;
    localparam int HT = 16;
    localparam int VT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [10:0] vcount_in, hcount_in;
    logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic [11:0] rgb_in;
    logic [19:0] rom_addr;
    logic [11:0] rom_data;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic [11:0] rgb_out;

    always #5 clk = ~clk;

    end_screen_draw #(.ADDR_WIDTH(20), .DATA_WIDTH(12), .FADE_FRAMES(FF)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .rom_addr(rom_addr), .rom_data(rom_data),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out)
    );

    function automatic logic [11:0] rom_f(input logic [19:0] a);
        if (a == 20'h00C05) return 12'hABC;
        if (a[3:0] == 4'd7) return 12'h8C4;
        return 12'hFFF;
    endfunction

    always_ff @(posedge clk) rom_data <= rom_f(rom_addr);

    typedef struct packed {
        logic [25:0] tim;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int h = 0, v = 0;
    int m_state = 0, m_level = 0, m_cnt = 0;

    function automatic logic [11:0] scale(input logic [11:0] c, input int lv);
        logic [11:0] r;
        for (int k = 0; k < 3; k++) r[k*4 +: 4] = 4'((int'(c[k*4 +: 4]) * lv) >> 4);
        return r;
    endfunction

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_level = 0; m_cnt = 0;
        q.delete();
        q.push_back('0);
    endtask

    task automatic model_update(input logic en, input logic fs);
        if (!en) begin
            m_state = 0; m_level = 0; m_cnt = 0;
        end else if (fs) begin
            if (m_state == 0) begin
                m_state = 1; m_level = 0; m_cnt = 0;
            end else if (m_state == 1) begin
                if (m_cnt == FF - 1) begin
                    m_cnt = 0;
                    m_level++;
                    if (m_level == 16) m_state = 2;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic apply();
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = (h >= 12);
        vblnk_in  = (v >= 6);
        hsync_in  = (h == 13 || h == 14);
        vsync_in  = (v == 7);
        rgb_in    = 12'($urandom);
    endtask

    task automatic step();
        exp_t        e;
        logic [19:0] exp_addr;
        apply();
        model_update(enable, (h == 0 && v == 0));
        exp_addr = {vcount_in[9:0], hcount_in[9:0]};
        e.tim = {vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in};
        if (hblnk_in || vblnk_in) e.rgb = 12'h000;
        else if (!enable)         e.rgb = rgb_in;
        else                      e.rgb = scale(rom_f(exp_addr), m_level);
        q.push_back(e);
        @(posedge clk);
        #1;
        check("rom_addr", 38'(rom_addr), 38'(exp_addr));
        if (q.size() >= 2) begin
            e = q.pop_front();
            check("timing", 38'({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out}),
                  38'(e.tim));
            check("rgb_out", 38'(rgb_out), 38'(e.rgb));
        end
        h++;
        if (h == HT) begin
            h = 0;
            v++;
            if (v == VT) v = 0;
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic run_frames(input int n);
        run_cycles(n * HT * VT);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_addr"}, 38'(rom_addr), 38'd0);
        check({tag, "_timing"},
              38'({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out}), 38'd0);
        check({tag, "_rgb"}, 38'(rgb_out), 38'd0);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        apply();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        model_reset();

        // Bypass, including blanked pixels.
        run_frames(1);

        // Full fade ramp from frame start; FULL at frame 64, then held (ABC pixel at 5,3).
        enable = 1'b1;
        run_frames(66);

        // Restart the ramp, run to level 9, drop enable mid-frame, re-enable mid-frame.
        enable = 1'b0;
        run_cycles(5);
        enable = 1'b1;
        run_cycles(HT * VT - 5);
        for (int i = 0; i < 80 && m_level != 9; i++) run_frames(1);
        run_cycles(3 * HT + 4);
        enable = 1'b0;
        run_cycles(20);
        enable = 1'b1;
        run_cycles(HT * VT - 3 * HT - 24);
        run_frames(2);

        // Enable falls exactly on a frame start that carries a level step.
        for (int i = 0; i < 10 && !(m_state == 1 && m_cnt == FF - 1); i++) run_frames(1);
        enable = 1'b0;
        step();
        enable = 1'b1;
        run_cycles(HT * VT - 1);
        run_frames(5);

        // Asynchronous reset mid-line at level 8.
        for (int i = 0; i < 80 && m_level != 8; i++) run_frames(1);
        run_cycles(2 * HT + 6);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        rst = 1'b0;
        model_reset();
        run_frames(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
